// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU memory sequencer and its load-alignment datapath.
package lsu_pkg;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned NBYTES = XLEN / 8;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_ILL = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2
  } lsu_ctrl_state_e;

  // Op fields kept after accept; ID/EX is free to move on once the op completes
  typedef struct packed {
    logic       is_load;
    logic       zero_ext;
    lsu_size_e  size;
    logic [4:0] rd;
    logic [1:0] off;
  } lsu_op_t;

  function automatic logic lsu_misaligned(lsu_size_e size, logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = addr_lo[0];
      SZ_W:    mis = (addr_lo != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction
endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Data-memory port: valid/ready request channel plus an unthrottled load-response channel.
interface lsu_mem_ctrl_if;
  logic                        mem_req_valid;
  logic                        mem_req_ready;
  logic                        mem_req_we;
  logic [lsu_pkg::XLEN-1:0]    mem_req_addr;
  logic [lsu_pkg::NBYTES-1:0]  mem_req_be;
  logic [lsu_pkg::XLEN-1:0]    mem_req_wdata;
  logic                        mem_rsp_valid;
  logic [lsu_pkg::XLEN-1:0]    mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/half/word from a memory word and zero- or sign-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  lsu_size_e       size,
  input  logic            zero_ext,
  output logic [XLEN-1:0] wb_data
);
  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    wb_data = shifted;
    case (size)
      SZ_B:    wb_data = {{(XLEN-8){~zero_ext & shifted[7]}}, shifted[7:0]};
      SZ_H:    wb_data = {{(XLEN-16){~zero_ext & shifted[15]}}, shifted[15:0]};
      default: wb_data = shifted;
    endcase
  end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// LSU memory sequencer: accepts one load/store from ID/EX, issues a valid/ready memory
// request, waits for load data under a timeout and emits a registered writeback.
module lsu_mem_ctrl #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic            is_load_in,
  input  logic            zero_ext_in,
  input  logic [1:0]      size_in,
  input  logic [4:0]      rd_in,
  input  logic [XLEN-1:0] addr_in,
  input  logic [XLEN-1:0] store_data_in,
  output logic            stall_out,
  lsu_mem_ctrl_if.master  mem,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            misalign_err,
  output logic            timeout_err
);
  import lsu_pkg::*;

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_ctrl_state_e  state_q, state_d;
  lsu_op_t          op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_valid_q, req_valid_d;
  logic             req_we_q, req_we_d;
  logic [XLEN-1:0]  req_addr_q, req_addr_d;
  logic [3:0]       req_be_q, req_be_d;
  logic [XLEN-1:0]  req_wdata_q, req_wdata_d;
  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
  logic             mis_err_q, mis_err_d;
  logic             to_err_q, to_err_d;

  lsu_size_e        size_c;
  logic             stall_c;
  logic [3:0]       be_c;
  logic [XLEN-1:0]  wdata_c;
  logic [XLEN-1:0]  align_c;

  assign size_c = lsu_size_e'(size_in);

  // Lane placement of store data and byte enables for the incoming op
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = store_data_in;
    case (size_c)
      SZ_B: begin
        be_c    = 4'b0001 << addr_in[1:0];
        wdata_c = {4{store_data_in[7:0]}};
      end
      SZ_H: begin
        be_c    = 4'b0011 << addr_in[1:0];
        wdata_c = {2{store_data_in[15:0]}};
      end
      default: ;
    endcase
  end

  lsu_load_align u_load_align (
    .rdata    (mem.mem_rsp_rdata),
    .off      (op_q.off),
    .size     (op_q.size),
    .zero_ext (op_q.zero_ext),
    .wb_data  (align_c)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    req_valid_d = req_valid_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_be_d    = req_be_q;
    req_wdata_d = req_wdata_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    mis_err_d   = 1'b0;
    to_err_d    = 1'b0;
    stall_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          if (lsu_misaligned(size_c, addr_in[1:0])) begin
            mis_err_d = 1'b1;
          end else begin
            stall_c     = 1'b1;
            op_d        = '{is_load: is_load_in, zero_ext: zero_ext_in, size: size_c,
                            rd: rd_in, off: addr_in[1:0]};
            req_valid_d = 1'b1;
            req_we_d    = ~is_load_in;
            req_addr_d  = {addr_in[XLEN-1:2], 2'b00};
            req_be_d    = be_c;
            req_wdata_d = wdata_c;
            state_d     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        stall_c = ~(mem.mem_req_ready & ~op_q.is_load);
        if (mem.mem_req_ready) begin
          req_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = op_q.is_load ? ST_WAIT_RSP : ST_IDLE;
        end
      end
      ST_WAIT_RSP: begin
        if (mem.mem_rsp_valid) begin
          wb_valid_d = (op_q.rd != 5'd0);
          wb_rd_d    = op_q.rd;
          wb_data_d  = align_c;
          state_d    = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          to_err_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      cnt_q       <= '0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_be_q    <= '0;
      req_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      mis_err_q   <= 1'b0;
      to_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      req_valid_q <= req_valid_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_be_q    <= req_be_d;
      req_wdata_q <= req_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      mis_err_q   <= mis_err_d;
      to_err_q    <= to_err_d;
    end
  end

  // Stall is the only combinational output; reset forces it low with the rest
  assign stall_out         = stall_c & ~rst;
  assign mem.mem_req_valid = req_valid_q;
  assign mem.mem_req_we    = req_we_q;
  assign mem.mem_req_addr  = req_addr_q;
  assign mem.mem_req_be    = req_be_q;
  assign mem.mem_req_wdata = req_wdata_q;
  assign wb_valid          = wb_valid_q;
  assign wb_rd             = wb_rd_q;
  assign wb_data           = wb_data_q;
  assign misalign_err      = mis_err_q;
  assign timeout_err       = to_err_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed scenarios plus randomized ops scored against a
// cycle-count/data model built from the load/store sequencing rules.
module tb_lsu_mem_ctrl;
  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, is_load_in, zero_ext_in;
  logic [1:0]  size_in;
  logic [4:0]  rd_in;
  logic [31:0] addr_in, store_data_in;
  logic        stall_out, wb_valid, misalign_err, timeout_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int errors = 0;
  int checks = 0;

  lsu_mem_ctrl_if mif ();

  lsu_mem_ctrl #(.XLEN(32), .TIMEOUT(T)) dut (
    .clk           (clk),
    .rst           (rst),
    .op_valid      (op_valid),
    .is_load_in    (is_load_in),
    .zero_ext_in   (zero_ext_in),
    .size_in       (size_in),
    .rd_in         (rd_in),
    .addr_in       (addr_in),
    .store_data_in (store_data_in),
    .stall_out     (stall_out),
    .mem           (mif),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .misalign_err  (misalign_err),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          done_at;
    int          stall_cycles;
    int          req_cycles;
    int          wb_cnt;
    int          wb_at;
    int          mis_cnt;
    int          to_cnt;
    int          to_at;
    logic        req_unstable;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
  } obs_t;

  // Expected behaviour of one op: d = REQ cycles before ready, r = WAIT cycles before response (-1 none)
  function automatic obs_t model(logic ld, logic zx, logic [1:0] sz, logic [4:0] rd,
                                 logic [31:0] addr, logic [31:0] sdata, int d, int r,
                                 logic [31:0] rdata);
    obs_t e;
    int nb, off;
    logic mis;
    logic [31:0] mask, v;
    e   = '0;
    off = int'(addr[1:0]);
    nb  = 1 << sz;
    mis = (sz == 2'd3) || ((off % nb) != 0);
    e.done_at      = mis ? 0 : (!ld ? 1 + d : (r >= 0 ? 2 + d + r : 1 + d + T));
    e.stall_cycles = e.done_at;
    e.req_cycles   = mis ? 0 : 1 + d;
    e.req_we       = !ld;
    e.req_addr     = addr & 32'hFFFF_FFFC;
    e.req_be       = (sz == 2'd2) ? 4'hF : 4'(((1 << nb) - 1) << off);
    e.req_wdata    = (sz == 2'd0) ? {24'd0, sdata[7:0]} * 32'h0101_0101 :
                     (sz == 2'd1) ? {16'd0, sdata[15:0]} * 32'h0001_0001 : sdata;
    mask = (nb >= 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 32'd1;
    v    = (rdata >> (8 * off)) & mask;
    if (!zx && nb < 4 && v[8*nb-1]) v = v | ~mask;
    e.wb_data = v;
    e.wb_rd   = rd;
    e.wb_cnt  = (!mis && ld && r >= 0 && rd != 5'd0) ? 1 : 0;
    e.wb_at   = 3 + d + r;
    e.mis_cnt = mis ? 1 : 0;
    e.to_cnt  = (!mis && ld && r < 0) ? 1 : 0;
    e.to_at   = 2 + d + T;
    return e;
  endfunction

  // Plays ID/EX and memory for one op; starts and ends just after a rising edge
  task automatic run_op(input logic ld, input logic zx, input logic [1:0] sz, input logic [4:0] rd,
                        input logic [31:0] addr, input logic [31:0] sdata, input int d, input int r,
                        input logic [31:0] rdata, input int tail, input bit scramble, output obs_t o);
    bit live = 1'b1;
    int rsp_at = -1;
    int rem = tail;
    o = '0;
    o.done_at = -1; o.wb_at = -1; o.to_at = -1;
    op_valid = 1'b1; is_load_in = ld; zero_ext_in = zx; size_in = sz;
    rd_in = rd; addr_in = addr; store_data_in = sdata;
    for (int k = 0; k < 200; k++) begin
      if (scramble && live && k >= 1) begin
        addr_in = $urandom; store_data_in = $urandom; size_in = 2'($urandom);
        zero_ext_in = 1'($urandom); rd_in = 5'($urandom); is_load_in = 1'($urandom);
      end
      mif.mem_req_ready = live && mif.mem_req_valid && (o.req_cycles == d);
      mif.mem_rsp_valid = (rsp_at == k);
      mif.mem_rsp_rdata = (rsp_at == k) ? rdata : $urandom;
      #1;
      if (live && stall_out) o.stall_cycles++;
      if (mif.mem_req_valid) begin
        if (o.req_cycles == 0) begin
          o.req_we = mif.mem_req_we; o.req_addr = mif.mem_req_addr;
          o.req_be = mif.mem_req_be; o.req_wdata = mif.mem_req_wdata;
        end else if ({o.req_we, o.req_addr, o.req_be, o.req_wdata} !==
                     {mif.mem_req_we, mif.mem_req_addr, mif.mem_req_be, mif.mem_req_wdata}) begin
          o.req_unstable = 1'b1;
        end
        o.req_cycles++;
        if (mif.mem_req_ready && r >= 0) rsp_at = k + 1 + r;
      end
      if (wb_valid) begin o.wb_cnt++; o.wb_at = k; o.wb_data = wb_data; o.wb_rd = wb_rd; end
      if (misalign_err) o.mis_cnt++;
      if (timeout_err) begin o.to_cnt++; o.to_at = k; end
      if (live && !stall_out) begin live = 1'b0; o.done_at = k; end
      @(posedge clk); #1;
      if (!live) begin
        op_valid = 1'b0;
        if (rem == 0) break;
        rem--;
      end
    end
    op_valid = 1'b0;
    mif.mem_req_ready = 1'b0;
    mif.mem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [150:0] outs;
    rst = 1'b1; op_valid = 1'b0; is_load_in = 1'b0; zero_ext_in = 1'b0; size_in = 2'd0;
    rd_in = 5'd0; addr_in = '0; store_data_in = '0;
    mif.mem_req_ready = 1'b0; mif.mem_rsp_valid = 1'b0; mif.mem_rsp_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    outs = {stall_out, mif.mem_req_valid, mif.mem_req_we, mif.mem_req_addr, mif.mem_req_be,
            mif.mem_req_wdata, wb_valid, wb_rd, wb_data, misalign_err, timeout_err};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h required 0", outs); end
    rst = 1'b0;
    @(posedge clk); #1;
    outs = {stall_out, mif.mem_req_valid, wb_valid, misalign_err, timeout_err};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL idle_after_reset: got %h required 0", outs); end
  endtask

  task automatic test_store_word();
    obs_t o;
    run_op(1'b0, 1'b0, 2'd2, 5'd0, 32'h100, 32'hDEAD_BEEF, 0, -1, '0, 2, 1'b0, o);
    checks++; if (o.req_addr !== 32'h100) begin errors++; $display("FAIL sw_addr: got %h required 00000100", o.req_addr); end
    checks++; if (o.req_be !== 4'b1111) begin errors++; $display("FAIL sw_be: got %b required 1111", o.req_be); end
    checks++; if (o.req_we !== 1'b1) begin errors++; $display("FAIL sw_we: got %b required 1", o.req_we); end
    checks++; if (o.req_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wdata: got %h required deadbeef", o.req_wdata); end
    checks++; if (o.stall_cycles != 1 || o.done_at != 1) begin errors++; $display("FAIL sw_timing: stall=%0d done=%0d required 1 1", o.stall_cycles, o.done_at); end
  endtask

  task automatic test_load_byte();
    obs_t o;
    run_op(1'b1, 1'b0, 2'd0, 5'd9, 32'h103, '0, 0, 0, 32'h80FF_FF11, 2, 1'b0, o);
    checks++; if (o.wb_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_sext_data: got %h required ffffff80", o.wb_data); end
    checks++; if (o.wb_rd !== 5'd9) begin errors++; $display("FAIL lb_rd: got %0d required 9", o.wb_rd); end
    checks++; if (o.wb_cnt != 1 || o.wb_at != 3) begin errors++; $display("FAIL lb_wb_timing: cnt=%0d at=%0d required 1 3", o.wb_cnt, o.wb_at); end
    run_op(1'b1, 1'b1, 2'd0, 5'd9, 32'h103, '0, 0, 0, 32'h80FF_FF11, 2, 1'b0, o);
    checks++; if (o.wb_data !== 32'h0000_0080) begin errors++; $display("FAIL lbu_zext_data: got %h required 00000080", o.wb_data); end
  endtask

  task automatic test_store_half_delayed();
    obs_t o;
    run_op(1'b0, 1'b0, 2'd1, 5'd0, 32'h202, 32'h0000_ABCD, 3, -1, '0, 2, 1'b0, o);
    checks++; if (o.req_be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b required 1100", o.req_be); end
    checks++; if (o.req_wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata: got %h required abcdabcd", o.req_wdata); end
    checks++; if (o.req_cycles != 4 || o.req_unstable) begin errors++; $display("FAIL sh_req_hold: cycles=%0d unstable=%0b required 4 0", o.req_cycles, o.req_unstable); end
  endtask

  task automatic test_misaligned();
    obs_t o;
    run_op(1'b1, 1'b0, 2'd2, 5'd4, 32'h105, '0, 0, 0, '0, 2, 1'b0, o);
    checks++; if (o.mis_cnt != 1) begin errors++; $display("FAIL mis_pulse: got %0d required 1", o.mis_cnt); end
    checks++; if (o.req_cycles != 0 || o.stall_cycles != 0) begin errors++; $display("FAIL mis_no_req: req=%0d stall=%0d required 0 0", o.req_cycles, o.stall_cycles); end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_op(1'b1, 1'b0, 2'd2, 5'd7, 32'h300, '0, 0, -1, '0, 2, 1'b0, o);
    checks++; if (o.to_cnt != 1 || o.to_at != 2 + T) begin errors++; $display("FAIL to_pulse: cnt=%0d at=%0d required 1 %0d", o.to_cnt, o.to_at, 2 + T); end
    checks++; if (o.wb_cnt != 0) begin errors++; $display("FAIL to_no_wb: got %0d required 0", o.wb_cnt); end
    run_op(1'b0, 1'b0, 2'd2, 5'd0, 32'h304, 32'h1, 0, -1, '0, 2, 1'b0, o);
    checks++; if (o.done_at != 1 || o.req_addr !== 32'h304) begin errors++; $display("FAIL to_next_op: done=%0d addr=%h required 1 00000304", o.done_at, o.req_addr); end
  endtask

  task automatic test_rd_zero();
    obs_t o;
    run_op(1'b1, 1'b0, 2'd2, 5'd0, 32'h400, '0, 1, 1, 32'h1234_5678, 2, 1'b0, o);
    checks++; if (o.wb_cnt != 0 || o.req_cycles != 2) begin errors++; $display("FAIL rd0: wb=%0d req=%0d required 0 2", o.wb_cnt, o.req_cycles); end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    run_op(1'b0, 1'b0, 2'd2, 5'd0, 32'h500, 32'h11, 0, -1, '0, 0, 1'b0, o);
    run_op(1'b0, 1'b0, 2'd0, 5'd0, 32'h509, 32'h22, 0, -1, '0, 2, 1'b0, o);
    checks++; if (o.done_at != 1 || o.stall_cycles != 1) begin errors++; $display("FAIL b2b_accept: done=%0d stall=%0d required 1 1", o.done_at, o.stall_cycles); end
    checks++; if (o.req_be !== 4'b0010 || o.req_wdata !== 32'h2222_2222) begin errors++; $display("FAIL b2b_req: be=%b wdata=%h required 0010 22222222", o.req_be, o.req_wdata); end
  endtask

  task automatic test_reset_mid_op();
    logic [150:0] outs;
    int wbs = 0, errs = 0, reqs = 0;
    op_valid = 1'b1; is_load_in = 1'b1; zero_ext_in = 1'b0; size_in = 2'd2;
    rd_in = 5'd3; addr_in = 32'h40;
    @(posedge clk); #1;
    checks++; if (mif.mem_req_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_req: got %b required 1", mif.mem_req_valid); end
    mif.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mif.mem_req_ready = 1'b0;
    rst = 1'b1; op_valid = 1'b0;
    @(posedge clk); #1;
    outs = {stall_out, mif.mem_req_valid, mif.mem_req_we, mif.mem_req_addr, mif.mem_req_be,
            mif.mem_req_wdata, wb_valid, wb_rd, wb_data, misalign_err, timeout_err};
    checks++; if (outs !== '0) begin errors++; $display("FAIL rst_mid_outputs: got %h required 0", outs); end
    rst = 1'b0;
    mif.mem_rsp_valid = 1'b1; mif.mem_rsp_rdata = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      mif.mem_rsp_valid = 1'b0;
      wbs += int'(wb_valid); errs += int'(misalign_err) + int'(timeout_err); reqs += int'(mif.mem_req_valid);
    end
    checks++; if (wbs != 0 || errs != 0 || reqs != 0) begin errors++; $display("FAIL rst_late_rsp: wb=%0d err=%0d req=%0d required 0 0 0", wbs, errs, reqs); end
  endtask

  task automatic test_random();
    obs_t o, e;
    logic ld, zx;
    logic [1:0] sz;
    logic [4:0] rd;
    logic [31:0] addr, sdata, rdata;
    int d, r;
    for (int n = 0; n < 60; n++) begin
      ld = 1'($urandom); zx = 1'($urandom); sz = 2'($urandom); rd = 5'($urandom);
      addr = $urandom; sdata = $urandom; rdata = $urandom;
      if ($urandom_range(1, 0) == 0) addr[1:0] = 2'b00;
      d = int'($urandom_range(3, 0));
      r = int'($urandom_range(T, 0)) - 1;
      e = model(ld, zx, sz, rd, addr, sdata, d, r, rdata);
      run_op(ld, zx, sz, rd, addr, sdata, d, r, rdata, 2, 1'b1, o);
      checks++; if (o.done_at != e.done_at) begin errors++; $display("FAIL rnd%0d_done: got %0d required %0d", n, o.done_at, e.done_at); end
      checks++; if (o.stall_cycles != e.stall_cycles) begin errors++; $display("FAIL rnd%0d_stall: got %0d required %0d", n, o.stall_cycles, e.stall_cycles); end
      checks++; if (o.req_cycles != e.req_cycles || o.req_unstable) begin errors++; $display("FAIL rnd%0d_req: cycles=%0d unstable=%0b required %0d 0", n, o.req_cycles, o.req_unstable, e.req_cycles); end
      checks++; if (o.mis_cnt != e.mis_cnt || o.to_cnt != e.to_cnt) begin errors++; $display("FAIL rnd%0d_err: mis=%0d to=%0d required %0d %0d", n, o.mis_cnt, o.to_cnt, e.mis_cnt, e.to_cnt); end
      checks++; if (o.wb_cnt != e.wb_cnt) begin errors++; $display("FAIL rnd%0d_wb_cnt: got %0d required %0d", n, o.wb_cnt, e.wb_cnt); end
      if (e.req_cycles > 0) begin
        checks++; if ({o.req_we, o.req_addr, o.req_be} !== {e.req_we, e.req_addr, e.req_be}) begin errors++; $display("FAIL rnd%0d_req_fields: we=%b addr=%h be=%b required %b %h %b", n, o.req_we, o.req_addr, o.req_be, e.req_we, e.req_addr, e.req_be); end
        if (!ld) begin
          checks++; if (o.req_wdata !== e.req_wdata) begin errors++; $display("FAIL rnd%0d_wdata: got %h required %h", n, o.req_wdata, e.req_wdata); end
        end
      end
      if (e.wb_cnt == 1) begin
        checks++; if (o.wb_data !== e.wb_data || o.wb_rd !== e.wb_rd || o.wb_at != e.wb_at) begin errors++; $display("FAIL rnd%0d_wb: data=%h rd=%0d at=%0d required %h %0d %0d", n, o.wb_data, o.wb_rd, o.wb_at, e.wb_data, e.wb_rd, e.wb_at); end
      end
      if (e.to_cnt == 1) begin
        checks++; if (o.to_at != e.to_at) begin errors++; $display("FAIL rnd%0d_to_at: got %0d required %0d", n, o.to_at, e.to_at); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_store_half_delayed();
    test_misaligned();
    test_timeout();
    test_rd_zero();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
